// File: rtl/fir_bcd_scan.sv
// TAPS-tap FIR with sequential MAC, iterative double-dabble and a multiplexed 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module fir_bcd_scan #(
    parameter int                     DATA_W      = 8,
    parameter int                     TAPS        = 4,
    parameter int                     COEF_W      = 4,
    parameter logic [TAPS*COEF_W-1:0] COEFS       = {4'd1, 4'd2, 4'd2, 4'd1},
    parameter int                     Y_W         = 16,
    parameter int                     DIGITS      = 4,
    parameter int                     REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in,
    input  logic                  go,
    output logic [Y_W-1:0]        y,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  sat,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int K_W    = $clog2(TAPS);
    localparam int CNT_W  = $clog2(Y_W + TAPS + 1);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(REFRESH_DIV + 1);
    localparam logic [63:0] DEC_MAX = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [63:0] BIN_MAX = (64'd1 << Y_W) - 64'd1;
    localparam logic [63:0] MAX     = (DEC_MAX < BIN_MAX) ? DEC_MAX : BIN_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_BCD} state_t;

    state_t              state_reg;
    logic                go_s1, go_s2, go_s3;
    logic                go_edge;
    logic [DATA_W-1:0]   line_reg [TAPS];
    logic [COEF_W-1:0]   coef [TAPS];
    logic [ACC_W-1:0]    acc_reg, acc_sum;
    logic [CNT_W-1:0]    cnt_reg;
    logic [K_W-1:0]      k;
    logic [Y_W-1:0]      bin_reg, y_work_reg;
    logic [4*DIGITS-1:0] bcd_work_reg, bcd_adj;
    logic                sat_work_reg;
    logic                over;

    assign go_edge = go_s2 & ~go_s3;
    assign k       = cnt_reg[K_W-1:0];
    assign acc_sum = acc_reg + ACC_W'(line_reg[k]) * ACC_W'(coef[k]);
    assign over    = 64'(acc_sum) > MAX;

    genvar gi;
    for (gi = 0; gi < TAPS; gi++) begin : g_coef
        assign coef[gi] = COEFS[gi*COEF_W +: COEF_W];
    end

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_work_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_work_reg[4*gi +: 4] + 4'd3 : bcd_work_reg[4*gi +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go_s1 <= 1'b0; go_s2 <= 1'b0; go_s3 <= 1'b0;
            state_reg <= S_IDLE;
            for (int i = 0; i < TAPS; i++) line_reg[i] <= '0;
            acc_reg <= '0; cnt_reg <= '0; bin_reg <= '0; y_work_reg <= '0;
            bcd_work_reg <= '0; sat_work_reg <= 1'b0;
            y <= '0; bcd <= '0; sat <= 1'b0; busy <= 1'b0; done <= 1'b0;
        end else begin
            go_s1 <= go; go_s2 <= go_s1; go_s3 <= go_s2;
            done  <= 1'b0;
            case (state_reg)
                S_IDLE: if (go_edge) begin
                    for (int i = TAPS - 1; i > 0; i--) line_reg[i] <= line_reg[i-1];
                    line_reg[0] <= in;
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                    busy      <= 1'b1;
                    state_reg <= S_MAC;
                end
                S_MAC: begin
                    acc_reg <= acc_sum;
                    if (cnt_reg == CNT_W'(TAPS - 1)) begin
                        sat_work_reg <= over;
                        y_work_reg   <= over ? Y_W'(MAX) : Y_W'(acc_sum);
                        bin_reg      <= over ? Y_W'(MAX) : Y_W'(acc_sum);
                        bcd_work_reg <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= S_BCD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_BCD: begin
                    if (cnt_reg == CNT_W'(Y_W)) begin
                        y         <= y_work_reg;
                        bcd       <= bcd_work_reg;
                        sat       <= sat_work_reg;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        bcd_work_reg <= {bcd_adj[4*DIGITS-2:0], bin_reg[Y_W-1]};
                        bin_reg      <= {bin_reg[Y_W-2:0], 1'b0};
                        cnt_reg      <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    logic [3:0]        digit [DIGITS];
    logic [DIGITS-1:0] blank;
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digit[gi] = bcd[4*gi +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS:0] lead_zero;
    assign lead_zero[DIGITS] = 1'b1;
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
        assign lead_zero[gi] = lead_zero[gi+1] && (digit[gi] == 4'd0);
        assign blank[gi]     = (gi != 0) && lead_zero[gi];
    end
`else
    assign blank = '0;
`endif

    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [DIG_W-1:0]  dig_idx_reg, idx_next;
    logic              scan_on_reg, on_next, wrap;
    logic [3:0]        cur_digit;
    logic [6:0]        seg_code;

    // an/seg are registered from the next index so they change on the advancing edge.
    always_comb begin
        wrap     = (scan_cnt_reg == SCAN_W'(REFRESH_DIV - 1));
        on_next  = scan_on_reg | wrap;
        idx_next = dig_idx_reg;
        if (wrap && scan_on_reg)
            idx_next = (dig_idx_reg == DIG_W'(DIGITS - 1)) ? '0 : dig_idx_reg + 1'b1;
        cur_digit = digit[idx_next];
        case (cur_digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
        if (blank[idx_next]) seg_code = 7'h7F;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_reg <= '0;
            dig_idx_reg  <= '0;
            scan_on_reg  <= 1'b0;
            an           <= '1;
            seg          <= 7'h7F;
        end else begin
            scan_cnt_reg <= wrap ? '0 : scan_cnt_reg + 1'b1;
            dig_idx_reg  <= idx_next;
            scan_on_reg  <= on_next;
            an           <= on_next ? ~(DIGITS'(1) << idx_next) : '1;
            seg          <= on_next ? seg_code : 7'h7F;
        end
    end
endmodule

// File: tb/tb_fir_bcd_scan.sv
// Bench for fir_bcd_scan: two instances (default and all-15 coefficients) share stimulus.
module tb_fir_bcd_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_s = 8'd0;
    logic        go = 1'b0;
    logic [15:0] y_a, y_b, bcd_a, bcd_b;
    logic        busy_a, busy_b, done_a, done_b, sat_a, sat_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;

    fir_bcd_scan #(.REFRESH_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .in(in_s), .go(go), .y(y_a), .bcd(bcd_a),
        .busy(busy_a), .done(done_a), .sat(sat_a), .an(an_a), .seg(seg_a));

    fir_bcd_scan #(.COEFS({4'd15, 4'd15, 4'd15, 4'd15}), .REFRESH_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .in(in_s), .go(go), .y(y_b), .bcd(bcd_b),
        .busy(busy_b), .done(done_b), .sat(sat_b), .an(an_b), .seg(seg_b));

    always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int done_cnt_a = 0, done_cnt_b = 0, exp_done = 0;
    int hist[4] = '{0, 0, 0, 0};
    int coef_a[4] = '{1, 2, 2, 1};
    int coef_b[4] = '{15, 15, 15, 15};
    logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_raw(input bit use_b);
        int s = 0;
        for (int k = 0; k < 4; k++) s += hist[k] * (use_b ? coef_b[k] : coef_a[k]);
        return s;
    endfunction

    function automatic int clamp(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    // Starts from go possibly high: one low sample, then go rises; c=0 is edge E.
    task automatic capture(input int sample, input bit interfere, output int lat);
        go = 1'b0;
        @(posedge clk); #1;
        in_s = 8'(sample);
        go = 1'b1;
        lat = -1;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sample;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) chk("busy_before_capture", busy_a, 0);
            if (c == 2) chk("busy_at_capture", busy_a, 1);
            if (interfere && c == 3) go = 1'b0;
            if (interfere && c == 4) begin go = 1'b1; in_s = ~in_s; end
            if (done_a) begin lat = c; break; end
        end
        exp_done++;
        chk("done_seen", lat >= 0, 1);
    endtask

    task automatic compare_model(input string tag, input int lat);
        int ya, yb, rb;
        ya = clamp(model_raw(1'b0));
        rb = model_raw(1'b1);
        yb = clamp(rb);
        chk({tag, "_latency"}, lat, 23);
        chk({tag, "_y_a"}, y_a, ya);
        chk({tag, "_bcd_a"}, bcd_a, to_bcd(ya));
        chk({tag, "_sat_a"}, sat_a, 0);
        chk({tag, "_y_b"}, y_b, yb);
        chk({tag, "_bcd_b"}, bcd_b, to_bcd(yb));
        chk({tag, "_sat_b"}, sat_b, rb > 9999);
        chk({tag, "_busy_after"}, busy_a, 0);
        $display("capture %s sample=%0d lat=%0d y_a=%0d y_b=%0d sat_b=%0b", tag, hist[0], lat, y_a, y_b, sat_b);
    endtask

    task automatic scan_check(input int val);
        bit found = 1'b0;
        logic [6:0] exp_seg;
        int d;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (an_a == 4'b1110) found = 1'b1;
        end
        chk("scan_found_digit0", found, 1);
        for (int i = 0; i < 4; i++) begin
            d = (val / (10 ** i)) % 10;
            exp_seg = (BLANK && i > 0 && val < 10 ** i) ? 7'h7F : seg_tab[d];
            chk("scan_an", an_a, 4'(~(4'b0001 << i)));
            chk("scan_seg", seg_a, exp_seg);
            $display("scan val=%0d digit=%0d an=%b seg=%h", val, i, an_a, seg_a);
            if (i < 3) begin repeat (4) @(posedge clk); #1; end
        end
    endtask

    typedef struct {
        int sample;
        int ya;
        int yb;
        bit satb;
    } vec_t;

    initial begin
        vec_t tab[10];
        int lat;
        tab[0] = '{10, 10, 150, 1'b0};
        tab[1] = '{20, 40, 450, 1'b0};
        tab[2] = '{30, 90, 900, 1'b0};
        tab[3] = '{40, 150, 1500, 1'b0};
        tab[4] = '{255, 415, 5175, 1'b0};
        tab[5] = '{255, 875, 8700, 1'b0};
        tab[6] = '{255, 1315, 9999, 1'b1};
        tab[7] = '{255, 1530, 9999, 1'b1};
        tab[8] = '{0, 1275, 9999, 1'b1};
        tab[9] = '{0, 765, 7650, 1'b0};

        // Power-on reset state and first scan assertion timing.
        repeat (3) @(posedge clk); #1;
        chk("rst_y", y_a, 0);
        chk("rst_bcd", bcd_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_an", an_a, 4'hF);
        chk("rst_seg", seg_a, 7'h7F);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("scan_pre_first_an", an_a, 4'hF);
        @(posedge clk); #1;
        chk("scan_first_an", an_a, 4'b1110);
        chk("scan_first_seg", seg_a, 7'h40);
        scan_check(0);

        // Warm-up capture, then reset asserted mid-MAC.
        capture(77, 1'b0, lat);
        compare_model("warmup", lat);
        go = 1'b0;
        @(posedge clk); #1;
        in_s = 8'd99;
        go = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_y", y_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_an", an_a, 4'hF);
        chk("midrst_seg", seg_a, 7'h7F);
        chk("midrst_sat_b", sat_b, 0);
        hist = '{0, 0, 0, 0};
        go = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (40) @(posedge clk); #1;
        chk("midrst_no_done", done_cnt_a, exp_done);
        chk("midrst_busy_idle", busy_a, 0);

        // Table: step response then saturation and recovery.
        for (int i = 0; i < 10; i++) begin
            capture(tab[i].sample, 1'b0, lat);
            chk("tab_latency", lat, 23);
            chk("tab_y_a", y_a, tab[i].ya);
            chk("tab_bcd_a", bcd_a, to_bcd(tab[i].ya));
            chk("tab_y_b", y_b, tab[i].yb);
            chk("tab_bcd_b", bcd_b, to_bcd(tab[i].yb));
            chk("tab_sat_b", sat_b, tab[i].satb);
            $display("capture table[%0d] sample=%0d lat=%0d y_a=%0d y_b=%0d sat_b=%0b",
                     i, tab[i].sample, lat, y_a, y_b, sat_b);
            if (i == 3) scan_check(150);
            if (i == 9) scan_check(765);
        end

        // Second go edge while busy is dropped; the next back-to-back capture is accepted.
        capture(123, 1'b1, lat);
        compare_model("interfere", lat);

        for (int r = 0; r < 20; r++) begin
            capture(int'($urandom_range(0, 255)), 1'b0, lat);
            compare_model("random", lat);
        end

        go = 1'b0;
        repeat (30) @(posedge clk); #1;
        chk("done_count_a", done_cnt_a, exp_done);
        chk("done_count_b", done_cnt_b, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_bcd_scan.md
# fir_bcd_scan

Parametrised FIR-to-display pipeline: captures an unsigned sample on each `go` press, computes a TAPS-tap FIR with a sequential multiply-accumulate, and converts the result to DIGITS BCD digits with an iterative double-dabble. The digits are then driven onto a multiplexed active-low 7-segment display. It is the next-generation replacement for the fixed 4-tap/4-digit FIR display top, adding configurable width, taps and digits, saturation, and busy/done status.

## Interface
- DATA_W, 8, sample width (unsigned)
- TAPS, 4, filter taps (2..16)
- COEF_W, 4, coefficient width (unsigned)
- COEFS, {4'd1,4'd2,4'd2,4'd1}, packed TAPS*COEF_W; bits [COEF_W-1:0] = tap 0 (newest sample)
- Y_W, 16, result width; must satisfy 2^Y_W >= 10^DIGITS
- DIGITS, 4, displayed decimal digits (1..8)
- REFRESH_DIV, 50000, clk cycles per digit in the scan

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in  in  DATA_W  sample input
- go  in  1  asynchronous capture request (pushbutton), level
- y  out  Y_W  last filtered, saturated result
- bcd  out  4*DIGITS  BCD of y; digit 0 in [3:0]
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse when y/bcd update
- sat  out  1  last result was clamped
- an  out  DIGITS  digit enables, active-low; an[0] = ones digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- `go` passes through a 2-flop synchroniser, followed by a rising-edge detector. An edge while busy=1 is discarded; there is no queuing.
- States are IDLE -> MAC -> BCD -> IDLE.
- **IDLE:** on a detected edge, shift `in` into the TAPS-deep delay line (tap 0 = new sample) and clear the accumulator. Then busy<=1 and go to MAC.
- **MAC:** one tap per cycle, acc += sample[k]*coef[k] for k = 0..TAPS-1. Accumulator width is DATA_W+COEF_W+clog2(TAPS); it never overflows.
- **End of MAC:** clamp to MAX = min(10^DIGITS-1, 2^Y_W-1). sat = (acc > MAX).
- **BCD:** shift-add-3 over Y_W cycles.
- **Completion:** y, bcd and sat register together, done pulses, busy<=0, return to IDLE.
- **Delay line:** entries not yet written hold 0 after reset.
- **Display scan:** a free-running counter advances the active digit every REFRESH_DIV cycles, in the order 0,1,..,DIGITS-1,0. Exactly one an bit is low at a time after the first advance. seg shows the registered bcd digit, with codes 0-9 standard and codes 10-15 fully blank (7'h7F). The scan runs independently of busy; the display changes only on done.
- **Reset (any time, including mid-computation):** y=0, bcd=0, sat=0, busy=0, done=0, delay line cleared, state IDLE. Display outputs are an=all ones and seg=7'h7F; the scan counter and digit index are 0.

## Timing
- Let E be the first clk edge sampling go=1 after go=0.
- The edge is detected and the sample captured at E+2, when busy rises.
- MAC occupies E+3..E+2+TAPS. BCD occupies the next Y_W cycles.
- done pulses, outputs update and busy falls at E+3+TAPS+Y_W. The default latency is 23 cycles.
- The earliest next accepted edge is one cycle after busy falls.
- go pulses shorter than one clk period may be missed. A long-held go produces one capture.
- The first an assertion occurs REFRESH_DIV cycles after reset release, on an[0].

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- **Defined:** digits above the most significant nonzero digit show seg=7'h7F while their an is still asserted. Digit 0 is never blanked, so a value of 0 shows a single "0".
- **Undefined:** all DIGITS digits display, including leading zeros (0 shows "0000").

## Test plan
- **Reset:** apply rst=0 mid-MAC. Require y=0, busy=0, an=4'hF, seg=7'h7F immediately, and no done afterwards.
- **Step response:** defaults, samples 10,20,30,40 captured in order. Required y after each capture: 10, 40, 90, 150. Final bcd=16'h0150, done exactly 23 cycles after the go edge.
- **Busy rejection:** a second go edge at E+5 is ignored (one done only). A go edge 2 cycles after busy falls is accepted.
- **Saturation:** COEFS all 15, four captures of 255. Require y=9999, bcd=16'h9999, sat=1. The next result below MAX clears sat.
- **Scan:** REFRESH_DIV=4, bcd=0150. Require an sequence 1110,1101,1011,0111 with seg 0=7'b1000000, 5, 1, 0.
- **Blanking:** with LEADING_ZERO_BLANK_EN, the digit-3 slot shows 7'h7F for y=150. A value of 0 shows "0" on digit 0 only.
